i2s_tx: RTL

- Audio serial transmitter that consumes the MCLK produced by the audio clock generator (11.2896 MHz from 60 MHz).
- Derives BCLK = MCLK/4 and LRCLK = BCLK/64 (44.1 kHz at nominal MCLK), and serialises 16-bit stereo PCM frames in I2S format.
- Frames are accepted from the audio decode/DMA path through a valid/accept handshake into a small FIFO.
- Sits between the audio sample source and the DAC pins in the top-level.

---
 rtl/i2s_tx_pkg.sv | 20 ++
 rtl/i2s_tx_fifo.sv | 52 +++++
 rtl/i2s_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: frame geometry and FSM encoding shared by the I2S transmitter.
// No ports; imported by i2s_tx and i2s_tx_fifo.
package i2s_tx_pkg;

  localparam int SLOTS_PER_FRAME = 64;
  localparam int BCLK_DIV        = 4;

  localparam int SLOT_W = $clog2(SLOTS_PER_FRAME);
  localparam int DIV_W  = $clog2(BCLK_DIV);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(BCLK_DIV - 1);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: synchronous FIFO holding stereo frames for the I2S transmitter.
// Ports: clk_i, rst_ni (async, active-low), push_i/data_i, pop_i/data_o,
// full_o, empty_o. Push when full and pop when empty are ignored.
module i2s_tx_fifo
  import i2s_tx_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S stereo transmitter; BCLK = MCLK/4, LRCLK = BCLK/64, frames
// buffered in a small FIFO and serialised MSB-first one BCLK after LRCLK.
// Ports: clk_i, rst_ni (async, active-low), mclk_i (sampled as data),
// enable_i, sample_l_i/sample_r_i/valid_i/accept_o (frame handshake),
// bclk_o, lrclk_o, sdata_o (DAC pins), underrun_o (pulse), busy_o.
// Build option I2S_TX_HOLD_LAST_EN: underrun replays the last popped frame.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mclk_i,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] sample_l_i,
  input  logic [SAMPLE_W-1:0] sample_r_i,
  input  logic                valid_i,
  output logic                accept_o,
  output logic                bclk_o,
  output logic                lrclk_o,
  output logic                sdata_o,
  output logic                underrun_o,
  output logic                busy_o
);

  localparam int FW = 2 * SAMPLE_W;
  localparam logic [4:0] LAST_BIT = 5'(SAMPLE_W);

  state_e state_q;
  state_e state_d;

  logic [2:0]          mclk_q;
  logic                tick;
  logic [DIV_W-1:0]    div_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [SLOT_W-1:0]   slot_nx;
  logic [4:0]          p_nx;
  logic                bit_slot;
  logic                fall;
  logic                wrap;
  logic                stop_now;
  logic                load;
  logic                halt;

  logic [FW-1:0]       fifo_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  logic [SAMPLE_W-1:0] shift_l;
  logic [SAMPLE_W-1:0] shift_r;
  logic [SAMPLE_W-1:0] ld_l;
  logic [SAMPLE_W-1:0] ld_r;
  logic                sdata_q;
  logic                underrun_q;

  i2s_tx_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (valid_i),
    .data_i  ({sample_l_i, sample_r_i}),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Two sync flops then an edge register: tick is the rising edge of
  // the synchronised MCLK.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mclk_q <= '0;
    else         mclk_q <= {mclk_q[1:0], mclk_i};
  end

  assign tick = mclk_q[1] && !mclk_q[2];

  assign fall     = tick && (state_q != STOPPED) && (div_q == LAST_DIV);
  assign wrap     = fall && (slot_q == LAST_SLOT);
  // A re-enable landing on the final DRAIN edge keeps running.
  assign stop_now = wrap && (state_q == DRAIN) && !enable_i;
  assign load     = wrap && !stop_now;
  assign pop      = load && !fifo_empty;
  assign halt     = (state_q == STOPPED) || stop_now;

  assign slot_nx  = slot_q + 1'b1;
  assign p_nx     = slot_nx[4:0];
  assign bit_slot = (p_nx != 5'd0) && (p_nx <= LAST_BIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= STOPPED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOPPED: if (enable_i) state_d = RUN;
      RUN:     if (!enable_i) state_d = DRAIN;
      DRAIN: begin
        if (stop_now)      state_d = STOPPED;
        else if (enable_i) state_d = RUN;
      end
      default: state_d = STOPPED;
    endcase
  end

  // Slot 63 is the idle slot so the first fall after start is a frame load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      slot_q <= LAST_SLOT;
    end else if (halt) begin
      div_q  <= '0;
      slot_q <= LAST_SLOT;
    end else if (tick) begin
      div_q <= div_q + 1'b1;
      if (fall) slot_q <= slot_nx;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  logic [FW-1:0] last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  last_q <= '0;
    else if (pop) last_q <= fifo_data;
  end

  assign ld_l = fifo_empty ? last_q[FW-1:SAMPLE_W] : fifo_data[FW-1:SAMPLE_W];
  assign ld_r = fifo_empty ? last_q[SAMPLE_W-1:0]  : fifo_data[SAMPLE_W-1:0];
`else
  assign ld_l = fifo_empty ? '0 : fifo_data[FW-1:SAMPLE_W];
  assign ld_r = fifo_empty ? '0 : fifo_data[SAMPLE_W-1:0];
`endif

  // Data shifts out MSB first during slots 1..SAMPLE_W of each half;
  // slot 0 carries the one-BCLK I2S delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_l    <= '0;
      shift_r    <= '0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= load && fifo_empty;
      if (halt) begin
        sdata_q <= 1'b0;
      end else if (fall) begin
        unique case (1'b1)
          load: begin
            shift_l <= ld_l;
            shift_r <= ld_r;
            sdata_q <= 1'b0;
          end
          bit_slot && !slot_nx[SLOT_W-1]: begin
            sdata_q <= shift_l[SAMPLE_W-1];
            shift_l <= shift_l << 1;
          end
          bit_slot && slot_nx[SLOT_W-1]: begin
            sdata_q <= shift_r[SAMPLE_W-1];
            shift_r <= shift_r << 1;
          end
          default: sdata_q <= 1'b0;
        endcase
      end
    end
  end

  assign accept_o   = !fifo_full;
  assign bclk_o     = div_q[DIV_W-1];
  assign lrclk_o    = slot_q[SLOT_W-1];
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;
  assign busy_o     = (state_q != STOPPED);

endmodule
